// File: rtl/mux_n_pipe.sv
// N:1 datapath multiplexer feeding a two-entry (main + skid) registered valid/ready stage.
// Out-of-range selects produce ERR_DATA tagged with out_err; flush drops every buffered beat.
module mux_n_pipe #(
    parameter int                WIDTH    = 16,
    parameter int                NUM_IN   = 4,
    parameter logic [WIDTH-1:0]  ERR_DATA = '0,
    localparam int               SEL_W    = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Handshake: a beat moves on a rising edge only when valid and ready are both 1
    // on that side; valid never waits for ready, and in_ready never depends on out_ready.
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_err_q,  main_err_d;
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q,  skid_err_d;
    logic             skid_valid_q, skid_valid_d;

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             accept;
    logic             emit;

    always_comb begin
        sel_data = ERR_DATA;
        sel_err  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(sel) == i) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    assign in_ready  = ~skid_valid_q & ~rst;
    assign accept    = in_valid & in_ready;
    assign emit      = main_valid_q & out_ready;
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;
    assign out_valid = main_valid_q;

    always_comb begin
        main_data_d  = main_data_q;
        main_err_d   = main_err_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_err_d   = skid_err_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // FULL: input side is closed, skid refills main once main drains.
            if (emit) begin
                main_data_d  = skid_data_q;
                main_err_d   = skid_err_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q) begin
            if (accept && emit) begin
                main_data_d = sel_data;
                main_err_d  = sel_err;
            end else if (accept) begin
                skid_data_d  = sel_data;
                skid_err_d   = sel_err;
                skid_valid_d = 1'b1;
            end else if (emit) begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            main_data_d  = sel_data;
            main_err_d   = sel_err;
            main_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q  <= '0;
            main_err_q   <= 1'b0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_err_q   <= main_err_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_err_q   <= skid_err_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: a 4-input and a 3-input instance share all handshake stimulus,
// checked against a two-deep FIFO model plus directed literal expectations.
module tb_mux_n_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, flush, in_valid, out_ready;
  logic [1:0]     sel;
  logic [W-1:0]   ins [4];
  logic [4*W-1:0] in_data;
  logic [3*W-1:0] in_data3;
  logic           in_ready, out_err, out_valid;
  logic [W-1:0]   out_data;
  logic           in_ready3, out_err3, out_valid3;
  logic [W-1:0]   out_data3;

  assign in_data  = {ins[3], ins[2], ins[1], ins[0]};
  assign in_data3 = in_data[3*W-1:0];

  mux_n_pipe #(.WIDTH(W), .NUM_IN(4), .ERR_DATA('0)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready));

  mux_n_pipe #(.WIDTH(W), .NUM_IN(3), .ERR_DATA('0)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data3), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
    .out_err(out_err3), .out_valid(out_valid3), .out_ready(out_ready));

  typedef struct packed {
    logic [W-1:0] d4;
    logic [W-1:0] d3;
    logic         e3;
  } beat_t;

  beat_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t make_beat();
    beat_t b;
    b.d4 = ins[sel];
    b.d3 = (int'(sel) < 3) ? ins[sel] : '0;
    b.e3 = (int'(sel) >= 3);
    return b;
  endfunction

  // Model: at most two beats in flight, FIFO order, rst/flush empty it.
  task automatic model_step();
    bit do_emit;
    bit do_acc;
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      do_emit = (exp_q.size() > 0) && out_ready;
      do_acc  = in_valid && (exp_q.size() < 2);
      if (do_emit) void'(exp_q.pop_front());
      if (do_acc) exp_q.push_back(make_beat());
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
  endtask

  always @(negedge clk) begin
    chk("out_valid", out_valid, exp_q.size() > 0);
    chk("out_valid3", out_valid3, exp_q.size() > 0);
    chk("in_ready", in_ready, (exp_q.size() < 2) && !rst);
    chk("in_ready3", in_ready3, (exp_q.size() < 2) && !rst);
    if (exp_q.size() > 0) begin
      chk("out_data", out_data, exp_q[0].d4);
      chk("out_err", out_err, 1'b0);
      chk("out_data3", out_data3, exp_q[0].d3);
      chk("out_err3", out_err3, exp_q[0].e3);
    end
  end

  initial begin
    logic [W-1:0] sw [4];
    int bias;
    sw = '{16'd256, 16'd1024, 16'd4096, 16'd7};

    // Reset with in_valid held high.
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; sel = 2'd0;
    for (int i = 0; i < 4; i++) ins[i] = W'($urandom);
    #1;
    chk("rst_in_ready_comb", in_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 16'd0);
      chk("rst_out_err", out_err, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);

    // Select sweep back-to-back; sel=3 is out of range for the 3-input instance.
    for (int i = 0; i < 4; i++) ins[i] = sw[i];
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      cycle();
      chk("sweep_valid", out_valid, 1'b1);
      chk("sweep_data", out_data, sw[i]);
      chk("sweep_err", out_err, 1'b0);
      chk("sweep_data3", out_data3, (i == 3) ? 16'd0 : sw[i]);
      chk("sweep_err3", out_err3, (i == 3) ? 1'b1 : 1'b0);
    end
    in_valid = 1'b0;
    cycle();
    chk("sweep_drain", out_valid, 1'b0);
    chk("sweep_drain3", out_valid3, 1'b0);

    // Stall: A=256 then B=1024 with out_ready low.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0; ins[0] = 16'd256;
    cycle();
    chk("stall_a", out_data, 16'd256);
    chk("stall_ready1", in_ready, 1'b1);
    ins[0] = 16'd1024;
    cycle();
    chk("stall_full", in_ready, 1'b0);
    chk("stall_hold", out_data, 16'd256);
    in_valid = 1'b0; ins[0] = 16'd999; sel = 2'd1;
    cycle();
    chk("stall_hold2", out_data, 16'd256);
    out_ready = 1'b1;
    cycle();
    chk("stall_b", out_data, 16'd1024);
    chk("stall_b_valid", out_valid, 1'b1);
    cycle();
    chk("stall_empty", out_valid, 1'b0);

    // Flush while FULL, then flush in ONE with a same-cycle accept.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0; ins[0] = 16'd11;
    cycle();
    ins[0] = 16'd22;
    cycle();
    flush = 1'b1; ins[0] = 16'd33;
    cycle();
    chk("flush_full_valid", out_valid, 1'b0);
    chk("flush_full_ready", in_ready, 1'b1);
    flush = 1'b0; ins[0] = 16'd44;
    cycle();
    chk("after_flush_data", out_data, 16'd44);
    flush = 1'b1; ins[0] = 16'd55;
    cycle();
    chk("flush_one_valid", out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("flush_no_ghost", out_valid, 1'b0);

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 10000; c++) begin
      bias      = ((c / 1000) % 2 == 1) ? 80 : 30;
      rst       = ($urandom_range(0, 399) == 0);
      flush     = !rst && ($urandom_range(0, 49) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 99) < bias);
      sel       = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) ins[i] = W'($urandom);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
